// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: opcode/funct constants, sequencer states, trap codes
// and the instruction-class decoder used by cycle_sequencer.
package cpu_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2a;

  typedef enum logic [5:0] {
    StId   = 6'd0,
    StIf   = 6'd1,
    StExec = 6'd2,
    StMem  = 6'd3,
    StWb   = 6'd4,
    StTrap = 6'd5
  } state_e;

  typedef enum logic [1:0] {
    TrapNone    = 2'd0,
    TrapIllegal = 2'd1,
    TrapTimeout = 2'd2
  } trap_code_e;

  typedef enum logic [3:0] {
    ClsLw, ClsSw, ClsAlu, ClsJal, ClsJr, ClsBeq, ClsBne, ClsJ, ClsIllegal
  } instr_cls_e;

  function automatic instr_cls_e decode_cls(input logic [5:0] opcode, input logic [5:0] funct);
    instr_cls_e cls;
    cls = ClsIllegal;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd, FnSub, FnSlt: cls = ClsAlu;
          FnJr:                cls = ClsJr;
          default:             cls = ClsIllegal;
        endcase
      end
      OpAddi, OpXori: cls = ClsAlu;
      OpJal:          cls = ClsJal;
      OpBeq:          cls = ClsBeq;
      OpBne:          cls = ClsBne;
      OpJ:            cls = ClsJ;
      OpLw:           cls = ClsLw;
      OpSw:           cls = ClsSw;
      default:        cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive memory not-ready cycle counter; expired flags the cycle whose wait would
// bring the count to MEM_WAIT_MAX.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] Limit = 8'(MEM_WAIT_MAX - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (count_en) begin
      count_d = count_q + 8'd1;
    end
  end

  // Independent of clear, which is itself derived from the next state.
  assign expired = count_en && (count_q >= Limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle CPU controller: IF/ID/EXEC/MEM/WB sequencing, write strobes and traps.
// Define CYCLE_SEQ_PERF_EN to add the cycle_count/instr_count performance counters.
module cycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  input  logic        trap_clr,
  output logic [5:0]  state,
  output logic        mem_req,
  output logic        pc_we,
  output logic        ir_we,
  output logic        ab_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_code
`ifdef CYCLE_SEQ_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_e     state_q, state_d;
  trap_code_e code_q, code_d;
  logic       alive_q, alive_d;
  instr_cls_e cls;
  logic       expired, wait_en, wait_clr;
  logic       mem_req_c, pc_we_c, ir_we_c, ab_we_c, reg_we_c, mem_we_c, done_c;

  assign cls     = decode_cls(opcode, funct);
  assign alive_d = 1'b1;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    mem_req_c = 1'b0;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    ab_we_c   = 1'b0;
    reg_we_c  = 1'b0;
    mem_we_c  = 1'b0;
    case (state_q)
      StIf: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = StId;
        end else if (expired) begin
          state_d = StTrap;
          code_d  = TrapTimeout;
        end
      end
      StId: begin
        ab_we_c = 1'b1;
        case (cls)
          ClsIllegal: begin
            state_d = StTrap;
            code_d  = TrapIllegal;
          end
          ClsJ: begin
            pc_we_c = 1'b1;
            state_d = StIf;
          end
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        case (cls)
          ClsJr: begin
            pc_we_c = 1'b1;
            state_d = StIf;
          end
          ClsBeq: begin
            pc_we_c = alu_zero;
            state_d = StIf;
          end
          ClsBne: begin
            pc_we_c = !alu_zero;
            state_d = StIf;
          end
          ClsLw, ClsSw: state_d = StMem;
          default:      state_d = StWb;
        endcase
      end
      StMem: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          if (cls == ClsSw) begin
            mem_we_c = 1'b1;
            state_d  = StIf;
          end else begin
            state_d = StWb;
          end
        end else if (expired) begin
          state_d = StTrap;
          code_d  = TrapTimeout;
        end
      end
      StWb: begin
        reg_we_c = 1'b1;
        pc_we_c  = (cls == ClsJal);
        state_d  = StIf;
      end
      StTrap: begin
        if (trap_clr) begin
          state_d = StIf;
          code_d  = TrapNone;
        end
      end
      default: state_d = StIf;
    endcase
    // Nothing moves until the first edge after reset release.
    if (!alive_q) begin
      state_d = state_q;
      code_d  = code_q;
    end
  end

  assign done_c   = (state_d == StIf) && (state_q != StIf) && (state_q != StTrap);
  assign wait_en  = alive_q && ((state_q == StIf) || (state_q == StMem)) && !mem_ready;
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_en(wait_en),
    .clear   (wait_clr),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIf;
      code_q  <= TrapNone;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      alive_q <= alive_d;
    end
  end

  assign state      = state_q;
  assign trap_code  = code_q;
  assign mem_req    = alive_q & mem_req_c;
  assign pc_we      = alive_q & pc_we_c;
  assign ir_we      = alive_q & ir_we_c;
  assign ab_we      = alive_q & ab_we_c;
  assign reg_we     = alive_q & reg_we_c;
  assign mem_we     = alive_q & mem_we_c;
  assign instr_done = alive_q & done_c;
  assign trap       = alive_q & (state_q == StTrap);

`ifdef CYCLE_SEQ_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (alive_q && (state_q != StTrap)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
    if (instr_done) begin
      instr_count_d = instr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: instruction-level model with per-cycle compare.
module tb_cycle_sequencer;

  localparam logic [5:0] S_ID = 6'd0, S_IF = 6'd1, S_EX = 6'd2, S_MEM = 6'd3, S_WB = 6'd4,
                         S_TRAP = 6'd5;
  localparam int MAXW = 15;

  logic clk, rst_n, alu_zero, mem_ready, trap_clr;
  logic [5:0] opcode, funct, state;
  logic mem_req, pc_we, ir_we, ab_we, reg_we, mem_we, instr_done, trap;
  logic [1:0] trap_code;
`ifdef CYCLE_SEQ_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  cycle_sequencer #(
    .MEM_WAIT_MAX(MAXW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .trap_clr  (trap_clr),
    .state     (state),
    .mem_req   (mem_req),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .ab_we     (ab_we),
    .reg_we    (reg_we),
    .mem_we    (mem_we),
    .instr_done(instr_done),
    .trap      (trap),
    .trap_code (trap_code)
`ifdef CYCLE_SEQ_PERF_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );

  typedef struct packed {
    logic [5:0] st;
    logic       mem_req, pc_we, ir_we, ab_we, reg_we, mem_we, done, trap;
    logic [1:0] code;
  } obs_t;

  obs_t  exp_v, act_v;
  logic  exp_valid;
  int    n_checks, n_pass, cyc_n;
  string cur_name;
  logic [5:0] cur_op, cur_fn;
  logic  cur_z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Single compare process: DUT outputs against the expectation set for this cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      act_v = '{st: state, mem_req: mem_req, pc_we: pc_we, ir_we: ir_we, ab_we: ab_we,
                reg_we: reg_we, mem_we: mem_we, done: instr_done, trap: trap, code: trap_code};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL %s cycle %0d: got st=%0d req,pc,ir,ab,reg,mem,done,trap=%b code=%0d; expected st=%0d req,pc,ir,ab,reg,mem,done,trap=%b code=%0d",
                    cur_name, cyc_n, act_v.st, act_v[9:2], act_v.code,
                    exp_v.st, exp_v[9:2], exp_v.code);
    end
  end

  // One cycle in state st: apply inputs after the edge and state what the outputs must be.
  task automatic drive(input logic [5:0] st, input logic rdy, input logic done,
                       input logic [1:0] code, input logic clr);
    logic is_r, is_jr;
    @(posedge clk);
    #1;
    opcode = cur_op; funct = cur_fn; alu_zero = cur_z; mem_ready = rdy; trap_clr = clr;
    is_r  = (cur_op == 6'h00);
    is_jr = is_r && (cur_fn == 6'h08);
    exp_v.st      = st;
    exp_v.mem_req = (st == S_IF) || (st == S_MEM);
    exp_v.ir_we   = (st == S_IF) && rdy;
    exp_v.pc_we   = ((st == S_IF) && rdy) || ((st == S_ID) && (cur_op == 6'h02)) ||
                    ((st == S_EX) && (is_jr || ((cur_op == 6'h04) && cur_z) ||
                                      ((cur_op == 6'h05) && !cur_z))) ||
                    ((st == S_WB) && (cur_op == 6'h03));
    exp_v.ab_we   = (st == S_ID);
    exp_v.reg_we  = (st == S_WB);
    exp_v.mem_we  = (st == S_MEM) && rdy && (cur_op == 6'h2b);
    exp_v.done    = done;
    exp_v.trap    = (st == S_TRAP);
    exp_v.code    = code;
    exp_valid     = 1'b1;
    cyc_n++;
  endtask

  task automatic trap_tail(input logic [1:0] code, inout int ncyc);
    drive(S_TRAP, rnd1(), 1'b0, code, 1'b0);
    drive(S_TRAP, rnd1(), 1'b0, code, 1'b0);
    drive(S_TRAP, rnd1(), 1'b0, code, 1'b1);
    ncyc += 3;
  endtask

  // Whole instruction: waits of MAXW or more in IF/MEM end in a timeout trap.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int if_w, input int mem_w, output int ncyc);
    logic [5:0] path[$];
    logic illegal;
    int w;
    cur_name = nm; cur_op = op; cur_fn = fn; cur_z = z;
    illegal = 1'b0;
    ncyc = 0;
    case (op)
      6'h23:               path = '{S_IF, S_ID, S_EX, S_MEM, S_WB};
      6'h2b:               path = '{S_IF, S_ID, S_EX, S_MEM};
      6'h08, 6'h0e, 6'h03: path = '{S_IF, S_ID, S_EX, S_WB};
      6'h04, 6'h05:        path = '{S_IF, S_ID, S_EX};
      6'h02:               path = '{S_IF, S_ID};
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h2a: path = '{S_IF, S_ID, S_EX, S_WB};
          6'h08:               path = '{S_IF, S_ID, S_EX};
          default: begin path = '{S_IF, S_ID}; illegal = 1'b1; end
        endcase
      end
      default: begin path = '{S_IF, S_ID}; illegal = 1'b1; end
    endcase
    for (int i = 0; i < path.size(); i++) begin
      logic last;
      last = (i == path.size() - 1);
      if ((path[i] == S_IF) || (path[i] == S_MEM)) begin
        w = (path[i] == S_IF) ? if_w : mem_w;
        if (w >= MAXW) begin
          for (int c = 0; c < MAXW; c++) drive(path[i], 1'b0, 1'b0, 2'd0, rnd1());
          ncyc += MAXW;
          trap_tail(2'd2, ncyc);
          return;
        end
        for (int c = 0; c < w; c++) drive(path[i], 1'b0, 1'b0, 2'd0, rnd1());
        drive(path[i], 1'b1, last, 2'd0, rnd1());
        ncyc += w + 1;
      end else begin
        drive(path[i], rnd1(), last && !illegal, 2'd0, rnd1());
        ncyc++;
      end
    end
    if (illegal) trap_tail(2'd1, ncyc);
  endtask

  initial begin
    int n;
    n_checks = 0; n_pass = 0; cyc_n = 0; exp_valid = 1'b0;
    cur_op = 6'h00; cur_fn = 6'h20; cur_z = 1'b0; cur_name = "reset";
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0;
    mem_ready = 1'b1; trap_clr = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_trap_code", 32'(trap_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("pre_alive_mem_req", 32'(mem_req), 32'd0);
    chk("pre_alive_pc_we", 32'(pc_we), 32'd0);

    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0, n);       chk("add_len", n, 4);
    run_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3, n);  chk("lw_wait3_len", n, 8);
    run_instr("beq_nt", 6'h04, 6'h00, 1'b0, 0, 0, n);    chk("beq_len", n, 3);
    run_instr("bne_t", 6'h05, 6'h00, 1'b0, 0, 0, n);     chk("bne_len", n, 3);
    run_instr("beq_t", 6'h04, 6'h00, 1'b1, 0, 0, n);
    run_instr("bne_nt", 6'h05, 6'h00, 1'b1, 0, 0, n);
    run_instr("sw", 6'h2b, 6'h00, 1'b0, 0, 2, n);        chk("sw_len", n, 6);
    run_instr("sub", 6'h00, 6'h22, 1'b1, 1, 0, n);
    run_instr("slt", 6'h00, 6'h2a, 1'b0, 0, 0, n);
    run_instr("addi", 6'h08, 6'h15, 1'b0, 0, 0, n);
    run_instr("xori", 6'h0e, 6'h3f, 1'b1, 0, 0, n);
    run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0, n);       chk("jal_len", n, 4);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0, n);        chk("jr_len", n, 3);
    run_instr("j", 6'h02, 6'h00, 1'b0, 0, 0, n);         chk("j_len", n, 2);
    run_instr("lw_ifwait2", 6'h23, 6'h00, 1'b0, 2, 0, n); chk("lw_ifwait2_len", n, 7);
    run_instr("illegal_op", 6'h3f, 6'h00, 1'b0, 0, 0, n); chk("illegal_op_len", n, 5);
    run_instr("illegal_fn", 6'h00, 6'h25, 1'b0, 0, 0, n);
    run_instr("if_timeout", 6'h00, 6'h20, 1'b0, MAXW, 0, n); chk("if_timeout_len", n, 18);
    run_instr("if_wait14", 6'h00, 6'h20, 1'b0, MAXW - 1, 0, n); chk("if_wait14_len", n, 18);
    run_instr("mem_timeout", 6'h23, 6'h00, 1'b0, 0, MAXW, n); chk("mem_timeout_len", n, 21);
    run_instr("mem_wait14", 6'h2b, 6'h00, 1'b0, 0, MAXW - 1, n);
    run_instr("add_after", 6'h00, 6'h20, 1'b0, 0, 0, n);

    // Reset asserted while SW is completing its memory write.
    cur_name = "sw_reset"; cur_op = 6'h2b; cur_fn = 6'h00; cur_z = 1'b0;
    drive(S_IF, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(S_ID, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(S_EX, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("sw_mem_we_before_rst", 32'(mem_we), 32'd1);
    chk("sw_state_before_rst", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("sw_mem_we_in_rst", 32'(mem_we), 32'd0);
    chk("sw_state_in_rst", 32'(state), 32'd1);
    chk("sw_mem_req_in_rst", 32'(mem_req), 32'd0);
`ifdef CYCLE_SEQ_PERF_EN
    chk("cycle_count_in_rst", cycle_count, 32'd0);
    chk("instr_count_in_rst", instr_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("add_post_rst", 6'h00, 6'h20, 1'b0, 0, 0, n); chk("add_post_rst_len", n, 4);
    run_instr("lw_post_rst", 6'h23, 6'h00, 1'b0, 1, 1, n);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Registered multi-cycle controller for the CPU datapath. It owns the state register (IF/ID/EXEC/MEM/WB), advances it per instruction class, and holds IF and MEM while the shared instruction/data memory is not ready. It generates the datapath write strobes and traps on illegal opcodes or memory timeouts. The per-state mux selects stay in the decode lookup table, which reads `state` from this block.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum consecutive not-ready cycles in one memory state before a timeout trap; range 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  instruction[31:26] from the IR; valid from ID onward.
- `funct`  in  6  instruction[5:0] from the IR.
- `alu_zero`  in  1  ALU zero flag, valid in EXEC.
- `mem_ready`  in  1  memory completes the access this cycle.
- `trap_clr`  in  1  leave TRAP, return to IF.
- `state`  out  6  current state: ID=0, IF=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- `mem_req`  out  1  memory access request.
- `pc_we`, `ir_we`, `ab_we`, `reg_we`, `mem_we`  out  1 each  datapath write strobes.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `trap`  out  1  high while in TRAP.
- `trap_code`  out  2  0 none, 1 illegal opcode, 2 memory timeout; held while in TRAP.

## Operation
- Sequences per class:
  - LW: IF→ID→EXEC→MEM→WB→IF.
  - SW: IF→ID→EXEC→MEM→IF.
  - ADD/SUB/SLT, ADDI, XORI, JAL: IF→ID→EXEC→WB→IF.
  - JR: IF→ID→EXEC→IF.
  - BEQ/BNE: IF→ID→EXEC→IF.
  - J: IF→ID→IF.
- Illegal input in ID: any other opcode, or an R-type funct that is not ADD/SUB/SLT/JR. The next state is TRAP with `trap_code`=1.
- IF: `mem_req`=1. On `mem_ready`=1, `ir_we`=`pc_we`=1 and go to ID. Otherwise hold.
- ID: `ab_we`=1.
- EXEC:
  - JR: `pc_we`=1.
  - BEQ: `pc_we`=`alu_zero`.
  - BNE: `pc_we`=!`alu_zero`.
- ID for J: `pc_we`=1.
- MEM (LW/SW): `mem_req`=1. On `mem_ready`, SW drives `mem_we`=1 and LW advances to WB. Otherwise hold.
- WB: `reg_we`=1. JAL additionally drives `pc_we`=1.
- `instr_done`=1 on the transition back to IF (including a not-taken branch).
- Wait counter (8 bit):
  - Increments every IF/MEM cycle with `mem_ready`=0.
  - Clears on state change.
  - When it reaches `MEM_WAIT_MAX` while `mem_ready`=0, the next state is TRAP with `trap_code`=2.
- TRAP: all strobes and `mem_req` are 0. `trap_clr`=1 returns to IF and clears `trap_code` and the counter. `trap_clr` outside TRAP is ignored.

## Timing
- Reset (async, `rst_n` low):
  - `state`=IF, counter 0, `trap_code`=0.
  - An internal `alive` flag is cleared. While it is 0, all strobes, `mem_req`, `instr_done` and `trap` are forced to 0.
  - `alive` sets on the first rising edge after `rst_n` deasserts. The first fetch request appears in the cycle after that edge.
- `state` is registered. Strobes are combinational from `state`, `opcode`, `funct`, `alu_zero` and `mem_ready`; no extra latency.
- Zero-wait instruction lengths: LW 5 cycles; SW/R/ADDI/XORI/JAL 4; JR/BEQ/BNE 3; J 2. Each wait cycle adds 1.
- `mem_ready`=1 in the same cycle the counter hits the limit: the access completes and no trap is taken.
- `rst_n` asserted mid-instruction: immediate return to IF with strobes low. No partial write is issued after the reset edge.

## Configuration
- `CYCLE_SEQ_PERF_EN` defined:
  - Adds outputs `cycle_count` [31:0], incremented every cycle `alive`=1, and `instr_count` [31:0], incremented on `instr_done`.
  - Both wrap at 2^32, are cleared by reset, and freeze while in TRAP.
- Undefined: neither port nor the counters exist.

## Structure
- Shared package `cpu_ctrl_pkg`: opcode/funct constants, state encodings (ID=0..TRAP=5), trap codes.
- Sub-module `mem_wait_timer`: the wait counter, with inputs `count_en` and `clear`, parameter `MEM_WAIT_MAX`, and output `expired`.

## Test plan
- Release reset with `opcode`=ADD and `mem_ready` held at 1 → states IF,ID,EXEC,WB,IF. `reg_we` high only in WB; `instr_done` pulses on the 4th cycle.
- LW with `mem_ready` low for 3 cycles in MEM → MEM held 4 cycles; WB follows; total 8 cycles.
- BEQ with `alu_zero`=0, then BNE with `alu_zero`=0 → `pc_we` low in EXEC for BEQ, high for BNE. Both return to IF after 3 cycles.
- Opcode 6'b111111 in ID → TRAP, `trap_code`=1, all strobes 0. `trap_clr` pulse → IF next cycle, `trap_code`=0.
- `MEM_WAIT_MAX`=15 with `mem_ready` low in IF → TRAP, `trap_code`=2 after 15 wait cycles. Repeat with `mem_ready`=1 on the 15th cycle → ID, no trap.
- `rst_n` pulsed low during SW MEM → `mem_we` drops immediately, `state`=IF. With `CYCLE_SEQ_PERF_EN` defined, both counters read 0.
